// File: rtl/spi_msg_packer.sv
// rtl/spi_msg_packer.sv - frames buffered result words into SYNC/HDR/payload/CSUM byte messages
//
// Purpose: buffers WORD_W-bit words with a channel tag in a small FIFO and
// serialises each one as a framed byte message on an 8-bit valid/ready stream.
// Frame: SYNC_BYTE, {ch[3:0], len[3:0]}, payload MSB byte first, XOR checksum.
//
// Ports:
//   clk_clk        - clock, rising edge
//   reset_reset_n  - asynchronous active-low reset
//   in_data        - word to send
//   in_channel     - source channel tag
//   in_valid       - word present
//   in_ready       - word accepted when in_valid & in_ready
//   out_data       - framed byte
//   out_valid      - byte present
//   out_ready      - downstream accepts byte
//   fifo_level     - words buffered, excluding the word being framed
//   drop_cnt       - words discarded while full (drop mode), saturating
//   busy           - a frame is in progress
module spi_msg_packer #(
    parameter int         WORD_W         = 32,
    parameter int         FIFO_DEPTH     = 16,
    parameter int         NUM_CH         = 4,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter bit         DROP_WHEN_FULL = 1'b0,
    localparam int        CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int        LVL_W          = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [WORD_W-1:0] in_data,
    input  logic [CH_W-1:0]   in_channel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LVL_W-1:0]  fifo_level,
    output logic [15:0]       drop_cnt,
    output logic              busy
);

    localparam int         PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [3:0] LEN   = 4'(WORD_W / 8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_HDR,
        S_PAY,
        S_CSUM
    } state_t;

    state_t state, state_n;

    // Word buffer
    logic [WORD_W-1:0] mem_data [FIFO_DEPTH];
    logic [CH_W-1:0]   mem_ch   [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              dropped;

    // Framing datapath
    logic [WORD_W-1:0] shreg, shreg_n;
    logic [3:0]        ch_q, ch_n;
    logic [3:0]        cnt, cnt_n;
    logic [7:0]        csum, csum_n;
    logic [7:0]        data_q, data_n;
    logic              valid_q, valid_n;
    logic              accept;
    logic [7:0]        hdr;
    logic [7:0]        top_byte;

    assign full    = (level == LVL_W'(FIFO_DEPTH));
    assign empty   = (level == '0);
    // Ready never looks at a same-cycle pop, so a full buffer refuses the push
    // even when the framer frees a slot on the same edge.
    assign in_ready = DROP_WHEN_FULL ? 1'b1 : !full;
    assign push     = in_valid && !full;
    assign dropped  = DROP_WHEN_FULL && in_valid && full;

    always_ff @(posedge clk_clk) begin
        if (push) begin
            mem_data[wr_ptr] <= in_data;
            mem_ch[wr_ptr]   <= in_channel;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            drop_cnt <= '0;
        end else begin
            // Depth is a power of two, so pointers wrap naturally.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (dropped && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign accept   = valid_q && out_ready;
    assign hdr      = {ch_q, LEN};
    assign top_byte = shreg[WORD_W-1 -: 8];

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state   <= S_IDLE;
            shreg   <= '0;
            ch_q    <= '0;
            cnt     <= '0;
            csum    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            ch_q    <= ch_n;
            cnt     <= cnt_n;
            csum    <= csum_n;
            data_q  <= data_n;
            valid_q <= valid_n;
        end
    end

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        ch_n    = ch_q;
        cnt_n   = cnt;
        csum_n  = csum;
        data_n  = data_q;
        valid_n = valid_q;
        pop     = 1'b0;

        case (state)
            S_IDLE: begin
                if (!empty) pop = 1'b1;
            end
            S_SYNC: begin
                if (accept) begin
                    data_n  = hdr;
                    csum_n  = hdr;
                    state_n = S_HDR;
                end
            end
            S_HDR: begin
                if (accept) begin
                    data_n  = top_byte;
                    csum_n  = csum ^ top_byte;
                    shreg_n = shreg << 8;
                    cnt_n   = LEN - 4'd1;
                    state_n = S_PAY;
                end
            end
            S_PAY: begin
                if (accept) begin
                    // cnt counts payload bytes still to follow the one on the bus.
                    if (cnt == 4'd0) begin
                        data_n  = csum;
                        state_n = S_CSUM;
                    end else begin
                        data_n  = top_byte;
                        csum_n  = csum ^ top_byte;
                        shreg_n = shreg << 8;
                        cnt_n   = cnt - 4'd1;
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        valid_n = 1'b0;
                        state_n = S_IDLE;
                    end
                end
            end
            default: begin
                valid_n = 1'b0;
                state_n = S_IDLE;
            end
        endcase

        // Starting a frame is shared by IDLE and back-to-back CSUM.
        if (pop) begin
            shreg_n = mem_data[rd_ptr];
            ch_n    = 4'(mem_ch[rd_ptr]);
            data_n  = SYNC_BYTE;
            valid_n = 1'b1;
            state_n = S_SYNC;
        end
    end

    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign fifo_level = level;
    assign busy       = (state != S_IDLE);

endmodule
